// File: rtl/riscv_insn_encoder.sv
// Program loader: encodes one RV32I instruction per request and writes it to
// instruction memory at an auto-incrementing word address.
module riscv_insn_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [4:0]        req_funct,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [20:0]       req_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ENC  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [4:0] OP_R    = 5'h0C;
  localparam logic [4:0] OP_I    = 5'h04;
  localparam logic [4:0] OP_LD   = 5'h00;
  localparam logic [4:0] OP_ST   = 5'h08;
  localparam logic [4:0] OP_BR   = 5'h18;
  localparam logic [4:0] OP_JAL  = 5'h1B;
  localparam logic [4:0] OP_JALR = 5'h19;
  localparam logic [4:0] OP_SYS  = 5'h1C;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  logic [1:0]        state_q, state_d;
  logic [4:0]        op_q, op_d, rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [3:0]        funct_q, funct_d;
  logic [20:0]       imm_q, imm_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic [2:0]  f3;
  logic [6:0]  opc;
  logic        accept;
  logic        unused_funct3;

  // funct bit 3 carries no meaning in any supported encoding
  assign unused_funct3 = req_funct[3];

  assign full      = count_q[ADDR_W];
  assign done      = (state_q == S_HALT);
  assign req_ready = (state_q == S_IDLE) & ~full & ~done;
  assign accept    = req_valid & req_ready;
  assign f3        = funct_q[2:0];
  assign opc       = {op_q, 2'b11};

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (op_q)
      OP_R:    enc_word = {1'b0, funct_q[3], 5'b0, rs2_q, rs1_q, f3, rd_q, opc};
      OP_I: begin
        if (f3 == 3'd1 || f3 == 3'd5)
          enc_word = {1'b0, funct_q[3], 5'b0, imm_q[4:0], rs1_q, f3, rd_q, opc};
        else
          enc_word = {imm_q[11:0], rs1_q, f3, rd_q, opc};
      end
      OP_LD: begin
        enc_word  = {imm_q[11:0], rs1_q, f3, rd_q, opc};
        enc_legal = (f3 == 3'd0) || (f3 == 3'd2);
      end
      OP_JALR: enc_word = {imm_q[11:0], rs1_q, 3'b000, rd_q, opc};
      OP_ST:   enc_word = {imm_q[11:5], rs2_q, rs1_q, f3, imm_q[4:0], opc};
      OP_BR: begin
        enc_word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3, imm_q[4:1], imm_q[11], opc};
        enc_legal = ((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd5)) && !imm_q[0];
      end
      OP_JAL: begin
        enc_word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opc};
        enc_legal = !imm_q[0];
      end
      OP_SYS:  enc_word = 32'h0000_0073;
      default: enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    funct_d     = funct_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = req_op;
          funct_d = {req_funct[4], req_funct[2:0]};
          rd_d    = req_rd;
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          imm_d   = req_imm;
          state_d = S_ENC;
        end
      end
      S_ENC: begin
        if (enc_legal) begin
          mem_wdata_d = enc_word;
          mem_we_d    = 1'b1;
          state_d     = S_WR;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (mem_ack) begin
          mem_we_d   = 1'b0;
          count_d    = count_q + 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
          state_d    = (op_q == OP_SYS) ? S_HALT : S_IDLE;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 5'h0;
      funct_q     <= 4'h0;
      rd_q        <= 5'h0;
      rs1_q       <= 5'h0;
      rs2_q       <= 5'h0;
      imm_q       <= 21'h0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_A;
      mem_wdata_q <= 32'h0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      funct_q     <= funct_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: doc/riscv_insn_encoder.md
Name: riscv_insn_encoder

Overview:
- Sequential encoder that is the inverse of the hardwired control decoder. It accepts one instruction request at a time, as an OP class, a Funct code and register/immediate fields, and assembles the 32-bit RV32I word.
- It writes the word into instruction memory at an auto-incrementing word address. It is used as the on-chip program loader and test-program generator that fills instruction RAM ahead of the CPU.
- It uses the same OP and Funct encodings the control decoder consumes, so loaded programs decode back to the requested control signals.

Parameters:
ADDR_W, 10, instruction-memory word-address width; capacity 2^ADDR_W words.
BASE_ADDR, 0, first word address written after reset.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  encoder can accept a request this cycle
req_op  input  5  instruction bits [6:2]: 0x0C R-ALU, 0x04 I-ALU, 0x00 load, 0x08 store, 0x18 branch, 0x1B jal, 0x19 jalr, 0x1C ecall
req_funct  input  5  [2:0]=funct3, [4]=funct7 bit 5, [3] ignored
req_rd  input  5  destination register
req_rs1  input  5  source register 1
req_rs2  input  5  source register 2
req_imm  input  21  signed immediate, right-aligned; low 12 bits for I/S, low 13 for B, all 21 for J
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  encoded instruction
mem_ack  input  1  memory accepted the write
count  output  ADDR_W+1  words written since reset
full  output  1  count == 2^ADDR_W
done  output  1  ecall written; encoder halted
err  output  1  sticky: illegal request seen

Behaviour:
- Reset (async, rst=1): state IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, done=0, err=0.
  - A write that is mid-flight when reset arrives is abandoned immediately.
- req_ready = (state==IDLE) & ~full & ~done.
- A request is accepted on a clock edge where req_valid & req_ready.
- FSM:
  - IDLE -> ENC on accept. All request fields are latched.
  - ENC (1 cycle): the encoded word is registered into mem_wdata.
    - Illegal request: set err, go to IDLE, no write, count unchanged.
    - Otherwise go to WR.
  - WR: mem_we=1; mem_addr and mem_wdata are held stable until mem_ack.
    - On a cycle with mem_ack: mem_we deasserts the next cycle, count+1, mem_addr+1. mem_addr wraps modulo 2^ADDR_W; count does not wrap.
    - Then go to HALT if the op was ecall, else IDLE.
  - HALT: done=1, req_ready=0. Left only by reset.
- Minimum latency, accept to mem_we: 2 cycles. Throughput: one word per 3 cycles when mem_ack is tied high.
- Encoding rules; opcode = {req_op, 2'b11}:
  - R: funct7 = {1'b0, funct[4], 5'b0}; rs2, rs1, funct3, rd.
  - I-ALU:
    - funct3 in {1,5}: imm[11:5] = {1'b0, funct[4], 5'b0}, imm[4:0] = req_imm[4:0].
    - Other funct3: imm[11:0] = req_imm[11:0].
  - Load: I-format with funct3 from req_funct.
  - jalr: I-format, funct3 forced to 0.
  - Store: S-format, imm[11:0].
  - Branch: B-format, imm[12:1].
  - jal: J-format, imm[20:1].
  - ecall: word = 0x00000073; other fields ignored.
- Illegal requests, each of which sets err:
  - req_op outside the eight listed codes.
  - Branch funct3 not in {0,1,5}.
  - Branch with req_imm[0]=1.
  - jal with req_imm[0]=1.
  - Load funct3 not in {0,2}.
- full rises on the same edge count reaches 2^ADDR_W. Further requests are never accepted, and done is unaffected.
- Simultaneous req_valid while not ready: ignored. The requester must hold the request, and the encoder does not capture it.

Test Plan:
- R-ALU: add x3,x1,x2 (op 0x0C, funct 0, rd 3, rs1 1, rs2 2) -> mem_wdata 0x002081B3, mem_addr 0, count 1. Then sub (funct 0x10) -> 0x402081B3 at addr 1.
- I and S formats: addi x1,x0,-1 (op 0x04, imm 0x1FFFFF) -> 0xFFF00093. Then sw x2,8(x1) (op 0x08, funct 2, imm 8) -> 0x0020A423.
- Branch: beq x1,x2,-4 (op 0x18, funct 0, imm -4) -> 0xFE208EE3. The same request with imm=-3 -> err=1, no mem_we, count unchanged.
- Back-pressure and ecall: hold mem_ack=0 for 5 cycles in WR -> mem_we, mem_addr and mem_wdata stable throughout. Then ecall -> 0x00000073 written, done=1, req_ready=0 permanently.
- Full and wrap: ADDR_W=2, five back-to-back addi requests -> four writes to addrs 0..3, count=4, full=1, and the fifth request is never accepted (req_ready=0).
- Reset mid-write: assert rst during WR -> mem_we=0 immediately (same cycle, asynchronous), count=0, mem_addr=BASE_ADDR. The next request writes at BASE_ADDR.
